// File: rtl/analog_pad_sequencer_pkg.sv
// Shared definitions for the analog pad sequencer: sequencer state encoding,
// register offsets within the 16-byte Wishbone window, and the byte-lane
// helper used by the register block.
package analog_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_WAIT1,
        ST_MAKE,
        ST_WAIT2
    } state_t;

    // Register index taken from adr[3:2]
    localparam logic [1:0] REG_REQ    = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_SETTLE = 2'd2;

    localparam int STATUS_BUSY_BIT = 31;

    // Expand the four byte selects into a 32-bit write mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/analog_pad_sequencer_if.sv
// Wishbone slave bus of the analog pad sequencer.
//   master : management core side (drives cyc/stb/we/sel/adr/dat_i)
//   slave  : sequencer register block (drives ack/dat_o)
interface analog_pad_sequencer_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/analog_pad_sequencer_wb_regs.sv
// Wishbone register block of the analog pad sequencer.
// Holds REQ and SETTLE, returns STATUS (ACT + busy), single-cycle ack.
// Ports:
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   bus                 : Wishbone slave modport
//   act, busy           : sequencer status for the STATUS register
//   req, settle         : programmed target mask and settle time
module analog_pad_wb_regs
    import analog_pad_pkg::*;
#(
    parameter int          NCH        = 6,
    parameter int          SETTLE_W   = 8,
    parameter int          SETTLE_DEF = 16,
    parameter logic [31:0] BASE_ADR   = 32'h3000_1000
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    analog_pad_sequencer_if.slave   bus,
    input  logic [NCH-1:0]          act,
    input  logic                    busy,
    output logic [NCH-1:0]          req,
    output logic [SETTLE_W-1:0]     settle
);

    logic        hit;
    logic        accept;
    logic [1:0]  offset;
    logic [31:0] wmask;
    logic [31:0] rdata;
    logic        unused_bits;

    assign hit    = (bus.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    // Not accepting while ack is high keeps each access to one ack pulse
    assign accept = bus.wbs_cyc_i & bus.wbs_stb_i & hit & ~bus.wbs_ack_o;
    assign offset = bus.wbs_adr_i[3:2];
    assign wmask  = lane_mask(bus.wbs_sel_i);
    assign unused_bits = ^{bus.wbs_adr_i[1:0], bus.wbs_dat_i, wmask};

    always_comb begin
        rdata = '0;
        case (offset)
            REG_REQ:    rdata[NCH-1:0] = req;
            REG_STATUS: begin
                rdata[NCH-1:0]         = act;
                rdata[STATUS_BUSY_BIT] = busy;
            end
            REG_SETTLE: rdata[SETTLE_W-1:0] = settle;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
            req           <= '0;
            settle        <= SETTLE_W'(SETTLE_DEF);
        end else begin
            bus.wbs_ack_o <= accept;
            bus.wbs_dat_o <= (accept && !bus.wbs_we_i) ? rdata : '0;
            if (accept && bus.wbs_we_i) begin
                case (offset)
                    REG_REQ: req <= (req & ~wmask[NCH-1:0])
                                  | (bus.wbs_dat_i[NCH-1:0] & wmask[NCH-1:0]);
                    REG_SETTLE: settle <= (settle & ~wmask[SETTLE_W-1:0])
                                  | (bus.wbs_dat_i[SETTLE_W-1:0] & wmask[SETTLE_W-1:0]);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/analog_pad_sequencer.sv
// Analog pad sequencer: moves GPIO pads between digital and analog mode with
// break-before-make ordering. The digital driver of a pad (io_oeb=1) is
// tri-stated before its analog switch closes and stays tri-stated until after
// the switch has opened.
// Ports:
//   wb_clk_i, wb_rst_ni : clock, asynchronous active-low reset
//   wbs                 : Wishbone slave (REQ / STATUS / SETTLE registers)
//   dig_oeb_i           : oeb from user logic for pads in digital mode
//   io_oeb_o            : registered pad output-enable-bar
//   ana_en_o            : analog switch enables
//   irq_o               : one-cycle pulse when a sequence completes
module analog_pad_sequencer
    import analog_pad_pkg::*;
#(
    parameter int          NCH        = 6,
    parameter int          SETTLE_W   = 8,
    parameter int          SETTLE_DEF = 16,
    parameter logic [31:0] BASE_ADR   = 32'h3000_1000
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    analog_pad_sequencer_if.slave wbs,
    input  logic [NCH-1:0]        dig_oeb_i,
    output logic [NCH-1:0]        io_oeb_o,
    output logic [NCH-1:0]        ana_en_o,
    output logic                  irq_o
);

    state_t              state, state_nxt;
    logic [NCH-1:0]      req, act, act_nxt, tgt, tgt_nxt;
    logic [NCH-1:0]      on_m, on_nxt, off_m, off_nxt;
    logic [NCH-1:0]      ana_nxt, oeb_nxt, force_oeb;
    logic [SETTLE_W-1:0] settle, settle_eff, cnt, cnt_nxt;
    logic                irq_nxt;
    logic                busy;

    assign busy = (state != ST_IDLE);
    // A zero settle time still waits one cycle
    assign settle_eff = (settle == '0) ? SETTLE_W'(1) : settle;

    analog_pad_wb_regs #(
        .NCH        (NCH),
        .SETTLE_W   (SETTLE_W),
        .SETTLE_DEF (SETTLE_DEF),
        .BASE_ADR   (BASE_ADR)
    ) u_regs (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .bus       (wbs),
        .act       (act),
        .busy      (busy),
        .req       (req),
        .settle    (settle)
    );

    always_comb begin
        state_nxt = state;
        act_nxt   = act;
        tgt_nxt   = tgt;
        on_nxt    = on_m;
        off_nxt   = off_m;
        cnt_nxt   = cnt;
        ana_nxt   = ana_en_o;
        irq_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req != act) begin
                    tgt_nxt   = req;
                    on_nxt    = req & ~act;
                    off_nxt   = act & ~req;
                    state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                ana_nxt   = ana_en_o & ~off_m;
                cnt_nxt   = settle_eff;
                state_nxt = ST_WAIT1;
            end
            ST_WAIT1: begin
                cnt_nxt = cnt - SETTLE_W'(1);
                if (cnt == SETTLE_W'(1)) state_nxt = ST_MAKE;
            end
            ST_MAKE: begin
                ana_nxt   = ana_en_o | on_m;
                cnt_nxt   = settle_eff;
                state_nxt = ST_WAIT2;
            end
            ST_WAIT2: begin
                cnt_nxt = cnt - SETTLE_W'(1);
                if (cnt == SETTLE_W'(1)) begin
                    act_nxt   = tgt;
                    irq_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Analog pads stay tri-stated; every pad touched by a running
        // sequence is held tri-stated until the sequence returns to idle.
        force_oeb = act | (busy ? (on_m | off_m) : '0);
        oeb_nxt   = force_oeb | dig_oeb_i;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= ST_IDLE;
            act      <= '0;
            tgt      <= '0;
            on_m     <= '0;
            off_m    <= '0;
            cnt      <= '0;
            ana_en_o <= '0;
            io_oeb_o <= '1;
            irq_o    <= 1'b0;
        end else begin
            state    <= state_nxt;
            act      <= act_nxt;
            tgt      <= tgt_nxt;
            on_m     <= on_nxt;
            off_m    <= off_nxt;
            cnt      <= cnt_nxt;
            ana_en_o <= ana_nxt;
            io_oeb_o <= oeb_nxt;
            irq_o    <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_analog_pad_sequencer.sv
module tb_analog_pad_sequencer;
    import analog_pad_pkg::*;

    localparam int          NCH    = 6;
    localparam logic [31:0] BASE   = 32'h3000_1000;
    localparam logic [31:0] A_REQ  = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_SET  = BASE + 32'h8;
    localparam logic [31:0] A_RSV  = BASE + 32'hC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [NCH-1:0] dig_oeb = '0;
    logic [NCH-1:0] io_oeb, ana_en;
    logic           irq;

    analog_pad_sequencer_if bus();

    analog_pad_sequencer #(
        .NCH(NCH), .SETTLE_W(8), .SETTLE_DEF(16), .BASE_ADR(BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs       (bus),
        .dig_oeb_i (dig_oeb),
        .io_oeb_o  (io_oeb),
        .ana_en_o  (ana_en),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [NCH-1:0] act_m = '0;   // reference model of ACT

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Break-before-make: an enabled analog switch always has its driver off
    always @(negedge clk) chk("invariant", 32'(ana_en & ~io_oeb), 32'h0);

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic got);
        bus.wbs_adr_i = adr;
        bus.wbs_we_i  = we;
        bus.wbs_dat_i = dat;
        bus.wbs_sel_i = sel;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        got  = 1'b0;
        rdat = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                got  = 1'b1;
                rdat = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        logic        got;
        wb_xfer(adr, 1'b1, dat, sel, d, got);
        chk("wr_ack", 32'(got), 32'h1);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] d);
        logic got;
        wb_xfer(adr, 1'b0, 32'h0, 4'hF, d, got);
        chk("rd_ack", 32'(got), 32'h1);
    endtask

    // Write REQ and check the whole sequence against the latency rules:
    // driver off at ack+2, switch change at ack+2 (off) / ack+S+3 (on),
    // irq at ack+2S+3, forcing released at ack+2S+4.
    task automatic run_seq(input logic [NCH-1:0] req, input int s, input logic [NCH-1:0] dig);
        logic [NCH-1:0] old, on, exp_ana, frc;
        logic [31:0]    r;
        int             se;
        old = act_m;
        on  = req & ~old;
        se  = (s == 0) ? 1 : s;
        dig_oeb = dig;
        @(negedge clk);
        wr(A_REQ, 32'(req), 4'hF);
        for (int k = 1; k <= 2 * se + 5; k++) begin
            @(negedge clk);
            exp_ana = ((k < 2) ? old : (old & req)) | ((k >= se + 3) ? on : '0);
            if (k == 1)               frc = old;
            else if (k <= 2 * se + 3) frc = old | req;
            else                      frc = req;
            chk("seq_ana", 32'(ana_en), 32'(exp_ana));
            chk("seq_oeb", 32'(io_oeb), 32'(frc | dig));
            chk("seq_irq", 32'(irq), 32'((req != old) && (k == 2 * se + 3)));
        end
        act_m = req;
        rd(A_STAT, r);
        chk("seq_status", r, 32'(req));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]    r;
        logic           got;
        int             irqs;
        logic [NCH-1:0] rq;
        int             s;

        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        dig_oeb = 6'h2A;

        // Reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_oeb", 32'(io_oeb), 32'h3F);
        chk("rst_ana", 32'(ana_en), 32'h0);
        chk("rst_ack", 32'(bus.wbs_ack_o), 32'h0);
        chk("rst_dat", bus.wbs_dat_o, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_oeb", 32'(io_oeb), 32'h2A);
        chk("rel_ana", 32'(ana_en), 32'h0);
        rd(A_STAT, r); chk("rel_status", r, 32'h0);
        rd(A_SET, r);  chk("rel_settle", r, 32'd16);
        rd(A_REQ, r);  chk("rel_req", r, 32'h0);

        // SETTLE=4, pads 0 and 2 to analog
        wr(A_SET, 32'd4, 4'hF);
        run_seq(6'h05, 4, 6'h00);

        // Pad 0 back to digital
        run_seq(6'h04, 4, 6'h00);

        // REQ rewritten while busy: first sequence finishes to 3F, then to 00
        dig_oeb = 6'h00;
        wr(A_REQ, 32'h3F, 4'hF);
        repeat (3) @(negedge clk);
        wr(A_REQ, 32'h00, 4'hF);
        irqs = 0;
        for (int k = 5; k <= 60 && irqs < 2; k++) begin
            @(negedge clk);
            if (irq) begin
                irqs++;
                if (irqs == 1) begin
                    chk("irq1_time", 32'(k), 32'd11);
                    chk("irq1_ana", 32'(ana_en), 32'h3F);
                end else begin
                    chk("irq2_time", 32'(k), 32'd22);
                    chk("irq2_ana", 32'(ana_en), 32'h00);
                end
            end
        end
        chk("irq_count", 32'(irqs), 32'd2);
        act_m = '0;
        rd(A_STAT, r); chk("overlap_status", r, 32'h0);

        // SETTLE=0 behaves as 1
        wr(A_SET, 32'd0, 4'hF);
        run_seq(6'h12, 0, 6'h21);

        // Byte lanes, reserved register, non-hit address
        wr(A_SET, 32'hFF, 4'h0);
        rd(A_SET, r); chk("sel0_settle", r, 32'h0);
        wr(A_REQ, 32'h3F, 4'h0);
        rd(A_REQ, r); chk("sel0_req", r, 32'h12);
        chk("sel0_ana", 32'(ana_en), 32'h12);
        wr(A_SET, 32'hFFFF_FF03, 4'h1);
        rd(A_SET, r); chk("lane0_settle", r, 32'h03);
        wr(A_SET, 32'h0000_AB00, 4'h2);
        rd(A_SET, r); chk("lane1_settle", r, 32'h03);
        wr(A_RSV, 32'hFFFF_FFFF, 4'hF);
        rd(A_RSV, r); chk("rsv_read", r, 32'h0);
        wb_xfer(32'h3000_2000, 1'b0, 32'h0, 4'hF, r, got);
        chk("nonhit_noack", 32'(got), 32'h0);

        // Randomised sequences
        for (int i = 0; i < 8; i++) begin
            s  = int'($urandom_range(0, 5));
            rq = NCH'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) rq = act_m;
            wr(A_SET, 32'(s), 4'hF);
            run_seq(rq, s, NCH'($urandom));
        end

        // Reset asserted in WAIT2
        wr(A_SET, 32'd4, 4'hF);
        dig_oeb = 6'h00;
        rq = ~act_m;
        wr(A_REQ, 32'(rq), 4'hF);
        repeat (8) @(negedge clk);
        chk("pre_rst_ana", 32'(ana_en), 32'(rq));
        #2 rst_n = 1'b0;
        #1;
        chk("async_ana", 32'(ana_en), 32'h0);
        chk("async_oeb", 32'(io_oeb), 32'h3F);
        chk("async_irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        act_m = '0;
        @(negedge clk);
        rd(A_REQ, r);  chk("post_req", r, 32'h0);
        rd(A_SET, r);  chk("post_settle", r, 32'd16);
        rd(A_STAT, r); chk("post_status", r, 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
